// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// Ports (slave = adder side):
//   in_valid/in_ready   operand beat handshake (a, b, cin, sub ride with it)
//   out_valid/out_ready result beat handshake (sum, cout, ovf, zero ride with it)
interface pipelined_cla_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Adder side: consumes operands, produces results.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

    // Environment side: produces operands, consumes results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one BLOCK-bit lookahead group
// resolved per stage, L = WIDTH/BLOCK stages, one operation per cycle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of pipelined_cla_adder_if:
//        in_valid/in_ready, a, b, cin, sub        operand beat
//        out_valid/out_ready, sum, cout, ovf, zero result beat (registered)
// in_ready is combinational from out_ready and the last stage valid bit.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_cla_adder_if.slave bus
);

    localparam int unsigned L = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH (%0d) must be a multiple of BLOCK (%0d)", WIDTH, BLOCK);
    end

    // Two-level lookahead: every carry is a flat OR of AND terms over the
    // group's p/g bits and the group carry-in, so nothing ripples in a group.
    function automatic logic [BLOCK:0] cla_carries(
        input logic [BLOCK-1:0] p,
        input logic [BLOCK-1:0] g,
        input logic             c0
    );
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < int'(BLOCK); i++) begin
            term = c0;
            for (int m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    // Stage k register: operand bits of groups above k (shifted down so the
    // next group sits at bit 0), sum groups 0..k in place, group k carry-out.
    logic [WIDTH-1:0] a_q [L];
    logic [WIDTH-1:0] a_d [L];
    logic [WIDTH-1:0] b_q [L];
    logic [WIDTH-1:0] b_d [L];
    logic [WIDTH-1:0] s_q [L];
    logic [WIDTH-1:0] s_d [L];
    logic [L-1:0]     c_q;
    logic [L-1:0]     c_d;
    logic [L-1:0]     v_q;
    logic [L-1:0]     v_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             zero_q;
    logic             zero_d;
    logic             adv;

    // Whole pipeline moves together; it only stalls with a blocked result.
    assign adv = !v_q[L-1] || bus.out_ready;
    assign v_d = L'({v_q, bus.in_valid});

    for (genvar k = 0; k < int'(L); k++) begin : g_stg
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   cc;

        if (k == 0) begin : g_src
            // Subtract as A + ~B + ~borrow.
            assign a_in = bus.a;
            assign b_in = bus.sub ? ~bus.b : bus.b;
            assign c_in = bus.cin ^ bus.sub;
            assign s_in = '0;
        end else begin : g_src
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign c_in = c_q[k-1];
            assign s_in = s_q[k-1];
        end

        assign p  = a_in[BLOCK-1:0] ^ b_in[BLOCK-1:0];
        assign g  = a_in[BLOCK-1:0] & b_in[BLOCK-1:0];
        assign cc = cla_carries(p, g, c_in);

        assign a_d[k] = a_in >> BLOCK;
        assign b_d[k] = b_in >> BLOCK;
        // Group k bits of s_in are always still zero, so OR inserts the group.
        assign s_d[k] = s_in | (WIDTH'(p ^ cc[BLOCK-1:0]) << (k * BLOCK));
        assign c_d[k] = cc[BLOCK];

        if (k == int'(L) - 1) begin : g_flags
            // Carry into the MSB is the last intra-group carry of this group.
            assign ovf_d  = cc[BLOCK-1] ^ cc[BLOCK];
            assign zero_d = ~|s_d[k];
        end
    end

    // Stage registers; everything holds while a result is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < int'(L); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q    <= v_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int k = 0; k < int'(L); k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v_q[L-1];
    assign bus.sum       = s_q[L-1];
    assign bus.cout      = c_q[L-1];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule
